// File: rtl/fractional_divider_if.sv
// -----------------------------------------------------------------------------
// fractional_divider_if
//
// Purpose: groups the operand handshake and the result bus of the fractional
// divider so producer and consumer see one bundle.
//
// Signals:
//   a            dividend, A_WIDTH bits
//   b            divisor, B_WIDTH bits
//   in_valid     producer has operands on a/b
//   in_ready     divider is idle and will take operands
//   result       quotient, OUTPUT_WIDTH bits, held until the next completion
//   out_valid    one-cycle pulse: result and flags were just updated
//   overflow     quotient saturated (qualified by out_valid)
//   div_by_zero  divisor was zero (qualified by out_valid)
//
// Modports:
//   master  drives operands, observes ready and results (testbench / upstream)
//   slave   the divider itself
// -----------------------------------------------------------------------------
interface fractional_divider_if #(
    parameter int A_WIDTH      = 16,
    parameter int B_WIDTH      = 16,
    parameter int OUTPUT_WIDTH = 16
);
    logic [A_WIDTH-1:0]      a;
    logic [B_WIDTH-1:0]      b;
    logic                    in_valid;
    logic                    in_ready;
    logic [OUTPUT_WIDTH-1:0] result;
    logic                    out_valid;
    logic                    overflow;
    logic                    div_by_zero;

    modport master (
        output a, b, in_valid,
        input  in_ready, result, out_valid, overflow, div_by_zero
    );

    modport slave (
        input  a, b, in_valid,
        output in_ready, result, out_valid, overflow, div_by_zero
    );
endinterface

// File: rtl/fractional_divider.sv
// -----------------------------------------------------------------------------
// fractional_divider
//
// Purpose: sequential fixed-point divider, result = a / b, with independent
// fractional formats on dividend, divisor and quotient. One restoring-division
// step per clock; quotient is truncated toward zero and saturated to
// OUTPUT_WIDTH bits. Signed mode divides magnitudes and applies the sign at the
// end; unsigned mode has no sign handling.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high; clears all state
//   bus      slave modport of fractional_divider_if (operands, handshake,
//                 result, overflow, div_by_zero, out_valid)
//   state_o  out  current FSM state (0=IDLE, 1=DIVIDE, 2=FINISH), for debug
//
// Handshake: operands are accepted on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE; in_valid outside IDLE is ignored (nothing is
// queued). Exactly N+1 cycles after acceptance out_valid pulses for one cycle
// with result/overflow/div_by_zero, and in_ready is already high in that cycle.
//
// Timing: S = FRAC_BITS_OUT - FRAC_BITS_A + FRAC_BITS_B, N = A_WIDTH + S.
// -----------------------------------------------------------------------------
module fractional_divider #(
    parameter int A_WIDTH          = 16,
    parameter int B_WIDTH          = 16,
    parameter int OUTPUT_WIDTH     = 16,
    parameter int FRAC_BITS_A      = 4,
    parameter int FRAC_BITS_B      = 4,
    parameter int FRAC_BITS_OUT    = 8,
    parameter bit areSignalsSigned = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    fractional_divider_if.slave  bus,
    output logic [1:0]           state_o
);

    localparam int S_RAW = FRAC_BITS_OUT - FRAC_BITS_A + FRAC_BITS_B;
    // Clamped copy keeps widths legal while the format error below is reported.
    localparam int S     = (S_RAW < 0) ? 0 : S_RAW;
    localparam int N     = A_WIDTH + S;
    localparam int CNT_W = $clog2(N + 1);
    localparam int RW    = B_WIDTH + 1;
    // Wide enough to hold the N-bit magnitude quotient and both output limits.
    localparam int WW    = ((N > OUTPUT_WIDTH) ? N : OUTPUT_WIDTH) + 1;

    if (S_RAW < 0) begin : g_bad_format
        $error("fractional_divider: FRAC_BITS_OUT - FRAC_BITS_A + FRAC_BITS_B must not be negative");
    end

    // Largest positive magnitude and largest negative magnitude the output holds.
    localparam logic [WW-1:0] POS_LIMIT = areSignalsSigned
        ? ((WW'(1) << (OUTPUT_WIDTH - 1)) - WW'(1))
        : ((WW'(1) << OUTPUT_WIDTH) - WW'(1));
    localparam logic [WW-1:0] NEG_LIMIT = WW'(1) << (OUTPUT_WIDTH - 1);

    localparam logic [OUTPUT_WIDTH-1:0] POS_FS = OUTPUT_WIDTH'(POS_LIMIT);
    localparam logic [OUTPUT_WIDTH-1:0] NEG_FS = OUTPUT_WIDTH'(NEG_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [N-1:0]            quo_q, quo_d;
    logic [B_WIDTH-1:0]      bmag_q, bmag_d;
    logic                    neg_q, neg_d;
    logic                    aneg_q, aneg_d;
    logic                    bzero_q, bzero_d;
    logic [OUTPUT_WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    dbz_q, dbz_d;
    logic                    ovalid_q, ovalid_d;

    logic                    a_neg, b_neg;
    logic [A_WIDTH-1:0]      a_mag;
    logic [B_WIDTH-1:0]      b_mag;
    logic [RW:0]             rem_shift;
    logic [WW-1:0]           q_wide;

    always_comb begin
        // Magnitudes fit in the operand width unsigned, so the most negative
        // value needs no special case.
        a_neg = areSignalsSigned && bus.a[A_WIDTH-1];
        b_neg = areSignalsSigned && bus.b[B_WIDTH-1];
        a_mag = a_neg ? (A_WIDTH'(0) - bus.a) : bus.a;
        b_mag = b_neg ? (B_WIDTH'(0) - bus.b) : bus.b;

        // The quotient register doubles as the numerator shifter: numerator
        // bits leave at the top while quotient bits enter at the bottom.
        rem_shift = {rem_q, quo_q[N-1]};
        q_wide    = WW'(quo_q);

        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        bmag_d   = bmag_q;
        neg_d    = neg_q;
        aneg_d   = aneg_q;
        bzero_d  = bzero_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        ovalid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bmag_d  = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    aneg_d  = a_neg;
                    bzero_d = (bus.b == '0);
                    rem_d   = '0;
                    quo_d   = N'(a_mag) << S;
                    cnt_d   = CNT_W'(N);
                    state_d = DIVIDE;
                end
            end

            DIVIDE: begin
                if (rem_shift >= {2'b00, bmag_q}) begin
                    rem_d = RW'(rem_shift - {2'b00, bmag_q});
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = RW'(rem_shift);
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                ovalid_d = 1'b1;
                state_d  = IDLE;
                if (bzero_q) begin
                    // Full scale with the dividend's sign; the quotient
                    // register content is meaningless here.
                    result_d = aneg_q ? NEG_FS : POS_FS;
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b1;
                end else if (neg_q) begin
                    dbz_d = 1'b0;
                    if (q_wide > NEG_LIMIT) begin
                        result_d = NEG_FS;
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = OUTPUT_WIDTH'(WW'(0) - q_wide);
                        ovf_d    = 1'b0;
                    end
                end else begin
                    dbz_d = 1'b0;
                    if (q_wide > POS_LIMIT) begin
                        result_d = POS_FS;
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = OUTPUT_WIDTH'(q_wide);
                        ovf_d    = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            bmag_q   <= '0;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            bmag_q   <= bmag_d;
            neg_q    <= neg_d;
            aneg_q   <= aneg_d;
            bzero_q  <= bzero_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.result      = result_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.out_valid   = ovalid_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_fractional_divider.sv
// -----------------------------------------------------------------------------
// tb_fractional_divider
//
// Drives a signed and an unsigned instance (default formats: N = 24) with
// directed operands whose quotients were worked out by hand. Expected
// responses go into per-instance queues when operands are accepted; monitors
// pop and compare on every out_valid, including the acceptance-to-out_valid
// latency.
// -----------------------------------------------------------------------------
module tb_fractional_divider;
    localparam int LAT    = 25;  // N + 1
    localparam int PERIOD = 26;  // N + 2

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    fractional_divider_if #(.A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(16)) s_bus ();
    fractional_divider_if #(.A_WIDTH(16), .B_WIDTH(16), .OUTPUT_WIDTH(16)) u_bus ();
    logic [1:0] s_state, u_state;

    fractional_divider #(.areSignalsSigned(1'b1)) dut_s (
        .clk(clk), .reset(reset), .bus(s_bus), .state_o(s_state)
    );
    fractional_divider #(.areSignalsSigned(1'b0)) dut_u (
        .clk(clk), .reset(reset), .bus(u_bus), .state_o(u_state)
    );

    // Scoreboard: {result, overflow, div_by_zero} plus acceptance cycle.
    logic [17:0] s_exp_q[$];
    int          s_acc_q[$];
    logic [17:0] u_exp_q[$];
    int          u_acc_q[$];
    int          s_pushed = 0, s_seen = 0;
    int          u_pushed = 0, u_seen = 0;
    logic [15:0] s_last_res = 16'h0000;
    int          prev_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: compare every out_valid against the oldest expectation.
    logic [17:0] s_mexp, u_mexp;
    int          s_macc, u_macc;

    always @(negedge clk) begin
        if (!reset && s_bus.out_valid) begin
            s_seen++;
            if (s_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_out_valid: got result 0x%0h with nothing expected", s_bus.result);
            end else begin
                s_mexp = s_exp_q.pop_front();
                s_macc = s_acc_q.pop_front();
                s_last_res = s_mexp[17:2];
                chk("s_result", 32'(s_bus.result), 32'(s_mexp[17:2]));
                chk("s_flags", {30'd0, s_bus.overflow, s_bus.div_by_zero}, {30'd0, s_mexp[1:0]});
                chk("s_latency", cyc - s_macc, LAT);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && u_bus.out_valid) begin
            u_seen++;
            if (u_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u_unexpected_out_valid: got result 0x%0h with nothing expected", u_bus.result);
            end else begin
                u_mexp = u_exp_q.pop_front();
                u_macc = u_acc_q.pop_front();
                chk("u_result", 32'(u_bus.result), 32'(u_mexp[17:2]));
                chk("u_flags", {30'd0, u_bus.overflow, u_bus.div_by_zero}, {30'd0, u_mexp[1:0]});
                chk("u_latency", cyc - u_macc, LAT);
            end
        end
    end

    // Driver: call at a negedge. Presents operands, waits for in_ready, records
    // the expectation for the acceptance edge, returns at the next negedge.
    task automatic issue(input bit uns, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic ovf, input logic dbz,
                         input bit hold, input bit chk_int);
        int t = 0;
        if (uns) begin
            u_bus.a = a; u_bus.b = b; u_bus.in_valid = 1'b1;
        end else begin
            s_bus.a = a; s_bus.b = b; s_bus.in_valid = 1'b1;
        end
        while (!(uns ? u_bus.in_ready : s_bus.in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!(uns ? u_bus.in_ready : s_bus.in_ready)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for a=0x%0h b=0x%0h", a, b);
            if (uns) u_bus.in_valid = 1'b0; else s_bus.in_valid = 1'b0;
            return;
        end
        if (uns) begin
            u_exp_q.push_back({res, ovf, dbz});
            u_acc_q.push_back(cyc + 1);
            u_pushed++;
        end else begin
            s_exp_q.push_back({res, ovf, dbz});
            s_acc_q.push_back(cyc + 1);
            s_pushed++;
        end
        if (chk_int) chk("b2b_interval", cyc + 1 - prev_acc, PERIOD);
        prev_acc = cyc + 1;
        @(negedge clk);
        if (!hold) begin
            if (uns) u_bus.in_valid = 1'b0; else s_bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((s_exp_q.size() != 0 || u_exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (s_exp_q.size() != 0 || u_exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d signed and %0d unsigned results missing",
                     s_exp_q.size(), u_exp_q.size());
            s_exp_q.delete(); s_acc_q.delete();
            u_exp_q.delete(); u_acc_q.delete();
        end
    endtask

    // Signed directed vectors: a, b, expected result, overflow, div_by_zero.
    localparam int NV = 15;
    logic [15:0] va [NV] = '{16'h0030, 16'hFFF0, 16'h0010, 16'hFFF0, 16'h7FFF,
                             16'h8000, 16'h0010, 16'hFFF0, 16'h8000, 16'h7FFF,
                             16'h0080, 16'h0010, 16'hFFF0, 16'h0000, 16'h0080};
    logic [15:0] vb [NV] = '{16'h0018, 16'h0040, 16'h0030, 16'h0030, 16'h0001,
                             16'h0001, 16'h0000, 16'h0000, 16'h0100, 16'h0100,
                             16'h0001, 16'h8000, 16'hFFF0, 16'h0000, 16'hFFFF};
    logic [15:0] vr [NV] = '{16'h0200, 16'hFFC0, 16'h0055, 16'hFFAB, 16'h7FFF,
                             16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF,
                             16'h7FFF, 16'h0000, 16'h0100, 16'h7FFF, 16'h8000};
    logic        vo [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vd [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        s_bus.a = '0; s_bus.b = '0; s_bus.in_valid = 1'b0;
        u_bus.a = '0; u_bus.b = '0; u_bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_result", 32'(s_bus.result), 32'h0);
        chk("rst_out_valid", 32'(s_bus.out_valid), 32'h0);
        chk("rst_overflow", 32'(s_bus.overflow), 32'h0);
        chk("rst_div_by_zero", 32'(s_bus.div_by_zero), 32'h0);
        chk("rst_in_ready", 32'(s_bus.in_ready), 32'h1);
        reset = 1'b0;
        @(negedge clk);

        // Directed signed vectors.
        for (int i = 0; i < NV; i++) begin
            issue(1'b0, va[i], vb[i], vr[i], vo[i], vd[i], 1'b0, 1'b0);
        end
        drain();

        // in_valid held high with new operands at every acceptance.
        issue(1'b0, 16'h0030, 16'h0018, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 16'hFFF0, 16'h0040, 16'hFFC0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 16'h0010, 16'h0030, 16'h0055, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 16'hFFF0, 16'h0030, 16'hFFAB, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // in_valid pulses while busy must be ignored; result must hold.
        issue(1'b0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        s_bus.a = 16'h0030; s_bus.b = 16'h0018; s_bus.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        s_bus.in_valid = 1'b0;
        chk("hold_result", 32'(s_bus.result), 32'(s_last_res));
        drain();

        // Reset asserted 10 cycles into a division aborts it.
        issue(1'b0, 16'h0030, 16'h0018, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_result", 32'(s_bus.result), 32'h0);
        chk("abort_overflow", 32'(s_bus.overflow), 32'h0);
        chk("abort_out_valid", 32'(s_bus.out_valid), 32'h0);
        chk("abort_in_ready", 32'(s_bus.in_ready), 32'h1);
        void'(s_exp_q.pop_back());
        void'(s_acc_q.pop_back());
        s_pushed--;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(1'b0, 16'hFFF0, 16'h0030, 16'hFFAB, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Unsigned instance.
        issue(1'b1, 16'hFFFF, 16'h0010, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 16'h0030, 16'h0018, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 16'hFFF0, 16'h0040, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 16'h0001, 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        drain();
        repeat (5) @(negedge clk);

        chk("s_out_valid_count", s_seen, s_pushed);
        chk("u_out_valid_count", u_seen, u_pushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fractional_divider.md
# fractional_divider

Sequential fixed-point divider computing result = a / b with independent fractional formats on dividend, divisor and quotient. It is the inverse counterpart of the team's fractional multiplier and shares its parameter set and signedness convention. It uses one restoring-division step per clock, a valid/ready handshake on input and a one-cycle valid pulse on output. It sits in the gain/normalisation path where a DSP multiplier cannot be used, for example computing reciprocals of calibration constants.

## Interface
- A_WIDTH, 16: dividend width (bits)
- B_WIDTH, 16: divisor width (bits)
- OUTPUT_WIDTH, 16: quotient width (bits)
- FRAC_BITS_A, 4: dividend fractional bits
- FRAC_BITS_B, 4: divisor fractional bits
- FRAC_BITS_OUT, 8: quotient fractional bits
- areSignalsSigned, 1: 1 = two's-complement operands and result; 0 = unsigned
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- a  in  A_WIDTH  dividend
- b  in  B_WIDTH  divisor
- in_valid  in  1  operands present
- in_ready  out  1  block idle, will accept operands
- result  out  OUTPUT_WIDTH  quotient, held until next completion
- out_valid  out  1  one-cycle pulse: result and flags updated
- overflow  out  1  quotient saturated (valid with result)
- div_by_zero  out  1  b was zero (valid with result)

## Operation
- S = FRAC_BITS_OUT - FRAC_BITS_A + FRAC_BITS_B. S < 0 is illegal and raises an elaboration error.
- N = A_WIDTH + S is the number of iterations.
- Arithmetic: Q = trunc_toward_zero((a_raw * 2^S) / b_raw), then saturated to OUTPUT_WIDTH.
- Signed mode:
  - Operate on magnitudes; |a| is held in A_WIDTH unsigned bits, so the most negative value is legal.
  - The result sign is sign(a) XOR sign(b).
  - Saturation range is [-2^(W-1), 2^(W-1)-1].
- Unsigned mode:
  - No sign handling.
  - Saturation range is [0, 2^W-1].
- Datapath:
  - Remainder register: B_WIDTH+1 bits.
  - Quotient shift register: N bits.
  - Down-counter: ceil(log2(N+1)) bits.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch the magnitudes, the sign, and whether b is zero. Clear the remainder and quotient, load counter=N, then go to DIVIDE.
  - DIVIDE: each cycle, shift the next numerator bit (MSB first) into the remainder. If remainder >= |b|, subtract |b| and shift 1 into the quotient; otherwise shift 0. Decrement the counter. When the counter reaches 0, go to FINISH.
  - FINISH: apply sign and saturation, register result/overflow/div_by_zero, pulse out_valid, then go to IDLE.
- Divide by zero:
  - Runs the full N cycles, so latency stays fixed.
  - result is the positive full-scale value, except in signed mode with a < 0, where it is the negative full-scale value.
  - div_by_zero=1 and overflow=0.
- overflow=1 only when the magnitude quotient exceeds the output range and b is nonzero.
- in_valid while not in IDLE is ignored; operands are not queued.

## Timing
- Reset values: result=0, out_valid=0, overflow=0, div_by_zero=0, in_ready=1, state IDLE.
- Acceptance happens on a rising edge where in_valid && in_ready.
- out_valid is high exactly N+1 cycles after the acceptance edge (defaults: N=24, so 25 cycles).
- in_ready is low from the cycle after acceptance through FINISH.
- in_ready returns high in the same cycle out_valid is high, so back-to-back throughput is one division per N+2 cycles.
- result, overflow and div_by_zero change only on the out_valid edge.
- Reset asserted mid-division aborts immediately: all outputs return to reset values, and no out_valid is produced for the aborted operation.
- a and b are sampled only at acceptance; later changes have no effect.

## Test plan
All scenarios use default parameters and signed mode unless stated otherwise.
- a=0x0030 (3.0), b=0x0018 (1.5) -> result=0x0200 (2.0), flags 0, out_valid 25 cycles after acceptance.
- a=0xFFF0 (-1.0), b=0x0040 (4.0) -> result=0xFFC0 (-0.25). a=0x0010, b=0x0030 -> 0x0055 (truncated). a=0xFFF0, b=0x0030 -> 0xFFAB (truncation toward zero).
- a=0x7FFF, b=0x0001 -> result=0x7FFF, overflow=1. a=0x8000, b=0x0001 -> result=0x8000, overflow=1.
- a=0x0010, b=0x0000 -> result=0x7FFF, div_by_zero=1, overflow=0. a=0xFFF0, b=0 -> result=0x8000, div_by_zero=1.
- Hold in_valid continuously with a new operand set each acceptance -> one out_valid every 26 cycles. in_valid pulses while busy -> ignored, no extra out_valid.
- Assert reset at cycle 10 of a division -> outputs zero, in_ready=1, no out_valid. A following division completes correctly. Unsigned mode: a=0xFFFF, b=0x0010 -> result=0xFFFF, overflow=1.
